// File: rtl/secret_sender.sv
// -----------------------------------------------------------------------------
// secret_sender
// Answers the keylock controller's sendSecret/doneSend handshake by printing
// the stored secret over an 8N1 UART line.  The message is the secret's hex
// digits in uppercase ASCII (most-significant digit first) followed by CR LF.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   NUM_DIGITS   : number of hex digits in the secret
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   sendSecret : request level from the controller; a rising edge starts a message
//   secret     : secret value, most-significant digit in the MSBs
//   tx         : UART serial output, idles high
//   doneSend   : one-cycle pulse when the final stop bit has completed
//   busy       : high while a message is in progress
// -----------------------------------------------------------------------------
module secret_sender #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_DIGITS   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sendSecret,
   input  logic [4*NUM_DIGITS-1:0] secret,
   output logic                    tx,
   output logic                    doneSend,
   output logic                    busy
);

   localparam int F  = NUM_DIGITS + 2;
   localparam int SW = 4 * NUM_DIGITS;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(F);

   localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(F - 1);
   localparam logic [IW-1:0] IDX_CR   = IW'(NUM_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      bit_q, bit_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [SW-1:0]   shreg_q, shreg_d;
   logic            send_q;
   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic [3:0]      digit;
   logic [7:0]      byte_cur;
   logic            bit_end;

   // The digit being printed always sits in the top nibble of the shift
   // register; it is shifted up once per completed digit byte.
   assign digit   = shreg_q[SW-1 -: 4];
   assign bit_end = (timer_q == T_LAST);

   always_comb begin
      byte_cur = 8'h0A;
      if (idx_q < IDX_CR) begin
         if (digit <= 4'd9) begin
            byte_cur = 8'h30 + {4'h0, digit};
         end else begin
            byte_cur = 8'h37 + {4'h0, digit};
         end
      end else if (idx_q == IDX_CR) begin
         byte_cur = 8'h0D;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            bit_d   = '0;
            idx_d   = '0;
            // Edge detect against the registered sample so a level that stays
            // high after completion cannot start another message.
            if (sendSecret && !send_q) begin
               state_d = S_START;
               shreg_d = secret;
            end
         end
         S_START: begin
            if (bit_end) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               timer_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  shreg_d = shreg_q << 4;
                  state_d = S_START;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are computed from the next state so that the registered
      // versions change on the same edge as the state itself.  The byte does
      // not change while in DATA, so the current byte is the right source.
      tx_d = 1'b1;
      if (state_d == S_START) begin
         tx_d = 1'b0;
      end else if (state_d == S_DATA) begin
         tx_d = byte_cur[bit_d];
      end
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         send_q  <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         send_q  <= sendSecret;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx       = tx_q;
   assign doneSend = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_secret_sender.sv
// -----------------------------------------------------------------------------
// tb_secret_sender
// Drives three secret_sender instances (CLKS_PER_BIT = 4, 2 and 434, all with
// four digits) and compares tx/doneSend/busy every cycle against a message
// model built directly from the ASCII/8N1 framing rules.
// -----------------------------------------------------------------------------
module tb_secret_sender;

   localparam int ND = 4;
   localparam int F  = ND + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        send   [3];
   logic [15:0] sec    [3];
   logic        tx_w   [3];
   logic        done_w [3];
   logic        busy_w [3];

   int checks = 0;
   int fails  = 0;
   int prints = 0;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int CPB = (gi == 0) ? 4 : ((gi == 1) ? 2 : 434);
         secret_sender #(
            .CLKS_PER_BIT(CPB),
            .NUM_DIGITS  (ND)
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .sendSecret(send[gi]),
            .secret    (sec[gi]),
            .tx        (tx_w[gi]),
            .doneSend  (done_w[gi]),
            .busy      (busy_w[gi])
         );
      end
   endgenerate

   function automatic int cpb_of(input int u);
      return (u == 0) ? 4 : ((u == 1) ? 2 : 434);
   endfunction

   // Byte i of the message for secret s: hex digits MSD first, then CR, LF.
   function automatic logic [7:0] model_byte(input logic [15:0] s, input int i);
      logic [3:0] d;
      if (i < ND) begin
         d = s[4*(ND-1-i) +: 4];
         return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
      end
      return (i == ND) ? 8'h0D : 8'h0A;
   endfunction

   // Line level of bit k of the whole message (10 bits per frame).
   function automatic logic model_bit(input logic [15:0] s, input int k);
      logic [7:0] b;
      int p;
      p = k % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      b = model_byte(s, k / 10);
      return b[p-1];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Requests one message on instance u and checks every cycle from E0 until
   // one cycle after doneSend.  drop_at / chg_at (cycles after E0, -1 = never)
   // drop sendSecret or overwrite secret mid-message.
   task automatic send_and_check(input int u, input logic [15:0] s,
                                 input int drop_at, input int chg_at,
                                 input bit use_const, input logic [7:0] cb [F]);
      int c;
      int total;
      logic eb;
      logic [7:0] rx [F];
      logic [7:0] eby;
      int p;
      c     = cpb_of(u);
      total = 10 * F * c;
      for (int i = 0; i < F; i++) rx[i] = 8'h00;
      send[u] = 1'b0;
      tick;
      sec[u]  = s;
      send[u] = 1'b1;
      tick;
      for (int n = 0; n <= total + 1; n++) begin
         eb = (n < total) ? model_bit(s, n / c) : 1'b1;
         checks++;
         if (tx_w[u] !== eb) begin
            fails++;
            if (prints < 30) $display("FAIL tx u%0d cycle %0d: got %b want %b", u, n, tx_w[u], eb);
            prints++;
         end
         checks++;
         if (done_w[u] !== (n == total)) begin
            fails++;
            if (prints < 30) $display("FAIL doneSend u%0d cycle %0d: got %b want %b", u, n, done_w[u], (n == total));
            prints++;
         end
         checks++;
         if (busy_w[u] !== (n <= total)) begin
            fails++;
            if (prints < 30) $display("FAIL busy u%0d cycle %0d: got %b want %b", u, n, busy_w[u], (n <= total));
            prints++;
         end
         // Mid-bit UART receiver for data bits.
         if (n < total && (n % c) == c / 2) begin
            p = (n / c) % 10;
            if (p >= 1 && p <= 8) rx[n / (10 * c)][p-1] = tx_w[u];
         end
         if (n == drop_at) send[u] = 1'b0;
         if (n == chg_at)  sec[u]  = 16'hFFFF;
         if (n <= total) tick;
      end
      for (int i = 0; i < F; i++) begin
         eby = use_const ? cb[i] : model_byte(s, i);
         checks++;
         if (rx[i] !== eby) begin
            fails++;
            $display("FAIL byte u%0d idx %0d: got %h want %h", u, i, rx[i], eby);
         end
      end
      $display("msg u%0d cpb=%0d secret=%h bytes=%h %h %h %h %h %h", u, c, s,
               rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int u = 0; u < 3; u++) begin
         send[u] = 1'b0;
         sec[u]  = 16'h0000;
      end
      tick;
      tick;
      for (int k = 0; k < 2; k++) begin
         for (int u = 0; u < 3; u++) begin
            checks++;
            if (tx_w[u] !== 1'b1 || done_w[u] !== 1'b0 || busy_w[u] !== 1'b0) begin
               fails++;
               $display("FAIL reset_state u%0d: got tx=%b done=%b busy=%b want 1 0 0",
                        u, tx_w[u], done_w[u], busy_w[u]);
            end
         end
         reset = 1'b0;
         tick;
      end
      $display("reset state checked");
   endtask

   task automatic test_basic;
      logic [7:0] cb [F];
      cb = '{8'h39, 8'h41, 8'h30, 8'h37, 8'h0D, 8'h0A};
      send_and_check(0, 16'h9A07, -1, -1, 1'b1, cb);
      send[0] = 1'b0;
      tick;
   endtask

   task automatic test_level_hold;
      logic [7:0] cb [F];
      cb = '{8'h39, 8'h41, 8'h30, 8'h37, 8'h0D, 8'h0A};
      send_and_check(0, 16'h9A07, -1, -1, 1'b1, cb);
      for (int n = 0; n < 50; n++) begin
         checks++;
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            fails++;
            if (prints < 30) $display("FAIL level_hold cycle %0d: got tx=%b busy=%b done=%b want 1 0 0",
                                      n, tx_w[0], busy_w[0], done_w[0]);
            prints++;
         end
         tick;
      end
      send_and_check(0, 16'h9A07, -1, -1, 1'b1, cb);
      send[0] = 1'b0;
      tick;
   endtask

   task automatic test_latch_early_drop;
      logic [7:0] cb [F];
      cb = '{8'h39, 8'h41, 8'h30, 8'h37, 8'h0D, 8'h0A};
      send_and_check(0, 16'h9A07, 20, 10, 1'b1, cb);
   endtask

   task automatic test_reset_mid_message;
      logic [7:0] cb [F];
      cb = '{8'h39, 8'h41, 8'h30, 8'h37, 8'h0D, 8'h0A};
      send[0] = 1'b0;
      tick;
      sec[0]  = 16'h9A07;
      send[0] = 1'b1;
      tick;
      for (int n = 0; n <= 100; n++) begin
         checks++;
         if (tx_w[0] !== model_bit(16'h9A07, n / 4)) begin
            fails++;
            if (prints < 30) $display("FAIL pre_reset_tx cycle %0d: got %b want %b", n, tx_w[0], model_bit(16'h9A07, n / 4));
            prints++;
         end
         if (n == 50) send[0] = 1'b0;
         if (n == 100) reset = 1'b1;
         tick;
      end
      for (int m = 0; m < 300; m++) begin
         checks++;
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            fails++;
            if (prints < 30) $display("FAIL post_reset cycle %0d: got tx=%b busy=%b done=%b want 1 0 0",
                                      m, tx_w[0], busy_w[0], done_w[0]);
            prints++;
         end
         if (m == 0) reset = 1'b0;
         tick;
      end
      $display("reset mid-message checked");
      send_and_check(0, 16'h9A07, 241, -1, 1'b1, cb);
   endtask

   task automatic test_hex_boundaries;
      logic [7:0] cb [F];
      cb = '{8'h30, 8'h46, 8'h39, 8'h41, 8'h0D, 8'h0A};
      send_and_check(0, 16'h0F9A, 241, -1, 1'b1, cb);
      send_and_check(1, 16'h0F9A, 121, -1, 1'b1, cb);
   endtask

   task automatic test_random;
      logic [7:0] cb [F];
      logic [15:0] s;
      cb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int r = 0; r < 8; r++) begin
         s = 16'($urandom);
         send_and_check(r % 2, s, int'($urandom_range(0, 110)),
                        int'($urandom_range(0, 110)), 1'b0, cb);
      end
   endtask

   task automatic test_default_params;
      logic [7:0] cb [F];
      cb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
      send_and_check(2, 16'h1234, 26041, -1, 1'b1, cb);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_level_hold;
      test_latch_early_drop;
      test_reset_mid_message;
      test_hex_boundaries;
      test_random;
      test_default_params;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
